// File: rtl/ps2_scancode_decoder.sv
// PS/2 set-2 scancode decoder: pops bytes from the receiver FIFO, folds E0/F0
// prefixes into key events, tracks shift/caps and translates keys to ASCII.
module ps2_scancode_decoder #(
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_kb_ready,
  input  logic [7:0]       i_kb_data,
  input  logic             i_kb_overflow,
  output logic             o_kb_nextdata,
  output logic             o_ev_valid,
  input  logic             i_ev_ready,
  output logic [7:0]       o_ev_code,
  output logic             o_ev_ext,
  output logic             o_ev_break,
  output logic [7:0]       o_ev_ascii,
  output logic             o_shift,
  output logic             o_caps,
  output logic [CNT_W-1:0] o_press_cnt,
  output logic             o_err
);

  // state | meaning
  // IDLE  | waiting for a byte in the receiver FIFO
  // ACK   | popping the latched byte and decoding it
  // EMIT  | presenting a key event until the consumer accepts it
  typedef enum logic [1:0] {S_IDLE, S_ACK, S_EMIT} state_t;

  state_t           r_state, w_state_nxt;
  logic [7:0]       r_byte;
  logic             r_ext_p, r_brk_p;
  logic             r_shift_l, r_shift_r, r_caps, r_caps_held;
  logic [7:0]       r_ev_code, r_ev_ascii;
  logic             r_ev_ext, r_ev_break;
  logic [CNT_W-1:0] r_press_cnt;
  logic             r_err;

  logic       w_is_prefix, w_proto_err;
  logic       w_shift_l_nxt, w_shift_r_nxt, w_caps_nxt, w_caps_held_nxt;
  logic [7:0] w_ascii;

  function automatic logic [7:0] f_ascii(input logic [7:0] code, input logic upper);
    logic [7:0] base;
    base = upper ? 8'h41 : 8'h61;
    case (code)
      8'h1C: f_ascii = base + 8'd0;
      8'h32: f_ascii = base + 8'd1;
      8'h21: f_ascii = base + 8'd2;
      8'h23: f_ascii = base + 8'd3;
      8'h24: f_ascii = base + 8'd4;
      8'h2B: f_ascii = base + 8'd5;
      8'h34: f_ascii = base + 8'd6;
      8'h33: f_ascii = base + 8'd7;
      8'h43: f_ascii = base + 8'd8;
      8'h3B: f_ascii = base + 8'd9;
      8'h42: f_ascii = base + 8'd10;
      8'h4B: f_ascii = base + 8'd11;
      8'h3A: f_ascii = base + 8'd12;
      8'h31: f_ascii = base + 8'd13;
      8'h44: f_ascii = base + 8'd14;
      8'h4D: f_ascii = base + 8'd15;
      8'h15: f_ascii = base + 8'd16;
      8'h2D: f_ascii = base + 8'd17;
      8'h1B: f_ascii = base + 8'd18;
      8'h2C: f_ascii = base + 8'd19;
      8'h3C: f_ascii = base + 8'd20;
      8'h2A: f_ascii = base + 8'd21;
      8'h1D: f_ascii = base + 8'd22;
      8'h22: f_ascii = base + 8'd23;
      8'h35: f_ascii = base + 8'd24;
      8'h1A: f_ascii = base + 8'd25;
      8'h45: f_ascii = 8'h30;
      8'h16: f_ascii = 8'h31;
      8'h1E: f_ascii = 8'h32;
      8'h26: f_ascii = 8'h33;
      8'h25: f_ascii = 8'h34;
      8'h2E: f_ascii = 8'h35;
      8'h36: f_ascii = 8'h36;
      8'h3D: f_ascii = 8'h37;
      8'h3E: f_ascii = 8'h38;
      8'h46: f_ascii = 8'h39;
      8'h29: f_ascii = 8'h20;
      8'h5A: f_ascii = 8'h0D;
      8'h66: f_ascii = 8'h08;
      default: f_ascii = 8'h00;
    endcase
  endfunction

  assign w_is_prefix = (r_byte == 8'hE0) || (r_byte == 8'hF0);
  // Any prefix arriving while a break prefix is pending is malformed.
  assign w_proto_err = w_is_prefix && r_brk_p;

  always_comb begin
    w_shift_l_nxt   = r_shift_l;
    w_shift_r_nxt   = r_shift_r;
    w_caps_nxt      = r_caps;
    w_caps_held_nxt = r_caps_held;
    if (!r_ext_p) begin
      case (r_byte)
        8'h12: w_shift_l_nxt = !r_brk_p;
        8'h59: w_shift_r_nxt = !r_brk_p;
        8'h58: begin
          if (r_brk_p) begin
            w_caps_held_nxt = 1'b0;
          end else begin
            w_caps_nxt      = r_caps ^ !r_caps_held;
            w_caps_held_nxt = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign w_ascii = r_ext_p ? 8'h00
                 : f_ascii(r_byte, (w_shift_l_nxt | w_shift_r_nxt) ^ w_caps_nxt);

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_kb_ready) w_state_nxt = S_ACK;
      S_ACK:   w_state_nxt = w_is_prefix ? S_IDLE : S_EMIT;
      S_EMIT:  if (i_ev_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_byte      <= '0;
      r_ext_p     <= 1'b0;
      r_brk_p     <= 1'b0;
      r_shift_l   <= 1'b0;
      r_shift_r   <= 1'b0;
      r_caps      <= 1'b0;
      r_caps_held <= 1'b0;
      r_ev_code   <= '0;
      r_ev_ext    <= 1'b0;
      r_ev_break  <= 1'b0;
      r_ev_ascii  <= '0;
      r_press_cnt <= '0;
      r_err       <= 1'b0;
    end else begin
      if (i_kb_overflow) r_err <= 1'b1;
      case (r_state)
        S_IDLE: if (i_kb_ready) r_byte <= i_kb_data;
        S_ACK: begin
          if (w_proto_err) begin
            r_err   <= 1'b1;
            r_ext_p <= 1'b0;
            r_brk_p <= 1'b0;
          end else if (r_byte == 8'hE0) begin
            r_ext_p <= 1'b1;
          end else if (r_byte == 8'hF0) begin
            r_brk_p <= 1'b1;
          end else begin
            r_ev_code   <= r_byte;
            r_ev_ext    <= r_ext_p;
            r_ev_break  <= r_brk_p;
            r_ev_ascii  <= w_ascii;
            r_shift_l   <= w_shift_l_nxt;
            r_shift_r   <= w_shift_r_nxt;
            r_caps      <= w_caps_nxt;
            r_caps_held <= w_caps_held_nxt;
            if (!r_brk_p) r_press_cnt <= r_press_cnt + 1'b1;
            r_ext_p     <= 1'b0;
            r_brk_p     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Gated by reset so a reset landing in ACK never pops a byte.
  assign o_kb_nextdata = (r_state == S_ACK) && !i_rst;
  assign o_ev_valid    = (r_state == S_EMIT);
  assign o_ev_code     = r_ev_code;
  assign o_ev_ext      = r_ev_ext;
  assign o_ev_break    = r_ev_break;
  assign o_ev_ascii    = r_ev_ascii;
  assign o_shift       = r_shift_l | r_shift_r;
  assign o_caps        = r_caps;
  assign o_press_cnt   = r_press_cnt;
  assign o_err         = r_err;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Bench for ps2_scancode_decoder: a byte-FIFO receiver model feeds the DUT and
// a byte-level reference model predicts every accepted key event.
module tb_ps2_scancode_decoder;

  logic       clk = 1'b0;
  logic       rst, kb_ready, kb_overflow, ev_ready;
  logic [7:0] kb_data;
  logic       kb_nextdata, ev_valid, ev_ext, ev_break, shift, caps, err;
  logic [7:0] ev_code, ev_ascii, press_cnt;

  always #5 clk = ~clk;

  ps2_scancode_decoder #(.CNT_W(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_kb_ready(kb_ready), .i_kb_data(kb_data),
    .i_kb_overflow(kb_overflow), .o_kb_nextdata(kb_nextdata), .o_ev_valid(ev_valid),
    .i_ev_ready(ev_ready), .o_ev_code(ev_code), .o_ev_ext(ev_ext),
    .o_ev_break(ev_break), .o_ev_ascii(ev_ascii), .o_shift(shift), .o_caps(caps),
    .o_press_cnt(press_cnt), .o_err(err)
  );

  typedef struct {
    logic [7:0] code; logic ext; logic brk; logic [7:0] ascii;
    logic shift; logic caps; logic [7:0] cnt;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] fifo[$];
  int         n_tests = 0, n_fail = 0, n_pops = 0, n_pushed = 0;
  logic       prev_pop = 1'b0;

  logic       m_ext, m_brk, m_sl, m_sr, m_caps, m_held, m_err;
  logic [7:0] m_cnt;
  logic [7:0] letters[26] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,
                              8'h3B,8'h42,8'h4B,8'h3A,8'h31,8'h44,8'h4D,8'h15,8'h2D,
                              8'h1B,8'h2C,8'h3C,8'h2A,8'h1D,8'h22,8'h35,8'h1A};
  logic [7:0] digits[10]  = '{8'h45,8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46};
  logic [7:0] pool[16]    = '{8'h1C,8'h32,8'h45,8'h16,8'h12,8'h59,8'h58,8'hE0,
                              8'hF0,8'h29,8'h5A,8'h66,8'h75,8'h05,8'hF0,8'h24};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    {m_ext, m_brk, m_sl, m_sr, m_caps, m_held, m_err} = '0;
    m_cnt = 8'd0;
  endtask

  function automatic logic [7:0] model_ascii(input logic [7:0] c, input logic upper);
    for (int i = 0; i < 26; i++)
      if (letters[i] == c) return (upper ? 8'h41 : 8'h61) + 8'(i);
    for (int i = 0; i < 10; i++)
      if (digits[i] == c) return 8'h30 + 8'(i);
    if (c == 8'h29) return 8'h20;
    if (c == 8'h5A) return 8'h0D;
    if (c == 8'h66) return 8'h08;
    return 8'h00;
  endfunction

  task automatic model_byte(input logic [7:0] b);
    ev_t e;
    if ((b == 8'hE0 || b == 8'hF0) && m_brk) begin
      m_err = 1'b1; m_ext = 1'b0; m_brk = 1'b0;
    end else if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
      if (!m_ext && b == 8'h12) m_sl = !m_brk;
      if (!m_ext && b == 8'h59) m_sr = !m_brk;
      if (!m_ext && b == 8'h58) begin
        if (m_brk) m_held = 1'b0;
        else begin
          if (!m_held) m_caps = !m_caps;
          m_held = 1'b1;
        end
      end
      if (!m_brk) m_cnt = m_cnt + 8'd1;
      e.code  = b; e.ext = m_ext; e.brk = m_brk;
      e.ascii = m_ext ? 8'h00 : model_ascii(b, (m_sl | m_sr) ^ m_caps);
      e.shift = m_sl | m_sr; e.caps = m_caps; e.cnt = m_cnt;
      exp_q.push_back(e);
      m_ext = 1'b0; m_brk = 1'b0;
    end
  endtask

  task automatic refresh();
    kb_ready = (fifo.size() != 0);
    kb_data  = (fifo.size() != 0) ? fifo[0] : 8'h00;
  endtask

  task automatic push_byte(input logic [7:0] b);
    fifo.push_back(b);
    model_byte(b);
    n_pushed++;
    refresh();
  endtask

  task automatic check_event();
    ev_t e;
    chk("spurious_event", exp_q.size() != 0, 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("ev_code", ev_code, e.code);
      chk("ev_ext", ev_ext, e.ext);
      chk("ev_break", ev_break, e.brk);
      chk("ev_ascii", ev_ascii, e.ascii);
      chk("shift", shift, e.shift);
      chk("caps", caps, e.caps);
      chk("press_cnt", press_cnt, e.cnt);
    end
  endtask

  task automatic cyc();
    logic pop;
    pop = kb_nextdata;
    if (pop) begin
      chk("double_pop", prev_pop, 0);
      chk("pop_nonempty", fifo.size() != 0, 1);
    end
    if (ev_valid && ev_ready) check_event();
    prev_pop = pop;
    @(posedge clk); #1;
    if (pop) begin
      n_pops++;
      if (fifo.size() != 0) void'(fifo.pop_front());
    end
    refresh();
  endtask

  task automatic drain(input int max);
    int i;
    ev_ready = 1'b1;
    for (i = 0; i < max; i++) begin
      if (fifo.size() == 0 && exp_q.size() == 0) break;
      cyc();
    end
    if (i == max) chk("drain_timeout", fifo.size() + exp_q.size(), 0);
    repeat (3) cyc();
    chk("pop_count", n_pops, n_pushed);
    chk("err", err, m_err);
    chk("caps_now", caps, m_caps);
    chk("shift_now", shift, m_sl | m_sr);
  endtask

  task automatic wait_valid(input int max);
    for (int i = 0; i < max && !ev_valid; i++) cyc();
    chk("wait_valid", ev_valid, 1);
  endtask

  initial begin
    rst = 1'b1; kb_overflow = 1'b0; ev_ready = 1'b0;
    model_reset();
    refresh();
    repeat (2) cyc();
    chk("rst_outputs", {kb_nextdata, ev_valid, ev_code, ev_ext, ev_break, ev_ascii,
                        shift, caps, press_cnt, err}, 0);
    rst = 1'b0;
    cyc();

    // Latency: ready in N, pop in N+1, event from N+2.
    push_byte(8'h1C);
    cyc();
    chk("lat_pop", kb_nextdata, 1);
    chk("lat_valid_early", ev_valid, 0);
    cyc();
    chk("lat_valid", ev_valid, 1);
    chk("lat_no_pop", kb_nextdata, 0);
    drain(50);

    push_byte(8'h1C); push_byte(8'hF0); push_byte(8'h1C);
    drain(100);

    foreach (pool[i]) if (0) ;
    push_byte(8'h12); push_byte(8'h1C); push_byte(8'hF0); push_byte(8'h12); push_byte(8'h1C);
    drain(100);

    push_byte(8'h58); push_byte(8'h58); push_byte(8'hF0); push_byte(8'h58); push_byte(8'h1C);
    drain(100);
    chk("caps_on", caps, 1);
    push_byte(8'h58); push_byte(8'hF0); push_byte(8'h58);
    drain(100);
    chk("caps_off", caps, 0);

    // Backpressure with a trailing byte waiting in the FIFO.
    ev_ready = 1'b0;
    push_byte(8'hE0); push_byte(8'hF0); push_byte(8'h75); push_byte(8'h1C);
    wait_valid(30);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("bp_valid", ev_valid, 1);
      chk("bp_no_pop", kb_nextdata, 0);
      chk("bp_event", {ev_code, ev_ext, ev_break, ev_ascii}, {8'h75, 1'b1, 1'b1, 8'h00});
    end
    drain(100);

    kb_overflow = 1'b1; cyc(); kb_overflow = 1'b0;
    m_err = 1'b1;
    chk("ovf_err", err, 1);
    repeat (3) cyc();
    chk("ovf_sticky", err, 1);

    rst = 1'b1; model_reset(); cyc(); rst = 1'b0; cyc();
    chk("err_cleared", err, 0);
    push_byte(8'hF0); push_byte(8'hF0); push_byte(8'h1C);
    drain(100);

    for (int n = 0; n < 400; n++) begin
      if (fifo.size() < 15 && ($urandom % 3) == 0) push_byte(pool[$urandom % 16]);
      ev_ready = ($urandom % 2) != 0;
      cyc();
    end
    drain(3000);

    // Reset while an event is pending.
    ev_ready = 1'b0;
    push_byte(8'h1C); push_byte(8'h32);
    wait_valid(30);
    rst = 1'b1;
    fifo.delete(); exp_q.delete(); model_reset();
    refresh();
    cyc();
    chk("rst_emit_outputs", {kb_nextdata, ev_valid, ev_code, ev_ext, ev_break, ev_ascii,
                             shift, caps, press_cnt, err}, 0);
    rst = 1'b0; ev_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("post_rst_quiet", {ev_valid, kb_nextdata}, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_scancode_decoder.md
# ps2_scancode_decoder

Downstream consumer of the PS/2 keyboard receiver's byte FIFO. It pops raw set-2 scancode bytes via the receiver's `ready`/`nextdata` handshake and folds the `E0` (extended) and `F0` (break) prefixes into single key events. It tracks shift and caps-lock state, translates common keys to ASCII, and presents each event on a valid/ready output port for display or CPU-side logic.

## Interface

- `CNT_W`, default 8: width of the make-event counter.

- `clk`  in  1  system clock, same domain as the receiver.
- `rst`  in  1  synchronous reset, active-high.
- `kb_ready`  in  1  receiver FIFO non-empty; `kb_data` valid.
- `kb_data`  in  8  FIFO head byte.
- `kb_overflow`  in  1  receiver overflow flag.
- `kb_nextdata`  out  1  one-cycle pop pulse to the receiver.
- `ev_valid`  out  1  key event available.
- `ev_ready`  in  1  consumer accepts the event.
- `ev_code`  out  8  scancode, with prefixes stripped.
- `ev_ext`  out  1  the event was `E0`-prefixed.
- `ev_break`  out  1  1 = key release, 0 = key press/repeat.
- `ev_ascii`  out  8  ASCII code, 0 if the key is unmapped.
- `shift`  out  1  left or right shift currently held.
- `caps`  out  1  caps-lock toggle state.
- `press_cnt`  out  CNT_W  count of emitted make events.
- `err`  out  1  sticky error flag.

## Operation

- FSM states: IDLE, ACK, EMIT. All state is registered; `kb_nextdata` = (state==ACK), `ev_valid` = (state==EMIT).
- **IDLE:**
  - If `kb_ready`=1, latch `kb_data` into `byte_r` and go to ACK.
  - Otherwise stay in IDLE.
- **ACK:** pop one byte and process `byte_r`:
  - `E0`: set `ext_p`, go to IDLE.
  - `F0`: if `brk_p` is already set, set `err`, clear both prefixes, go to IDLE. Otherwise set `brk_p`, go to IDLE.
  - `E0` while `brk_p`=1: protocol error. Set `err`, clear both prefixes, go to IDLE.
  - Any other byte: load the event registers (`ev_code`=`byte_r`, `ev_ext`=`ext_p`, `ev_break`=`brk_p`), update modifier state, compute `ev_ascii`, clear both prefixes, go to EMIT.
- **EMIT:** hold all event outputs. When `ev_ready`=1, return to IDLE.
- **Modifiers** (non-extended codes only):
  - `12` (left shift) and `59` (right shift): make sets the per-side held bit, break clears it. `shift` = L|R.
  - `58` (caps lock): make toggles `caps` only if `caps_held`=0, then sets `caps_held`. Break clears `caps_held`. Typematic repeats therefore do not re-toggle.
- **ASCII mapping**, evaluated with the modifier state *after* this event's update. All extended codes map to 0, and so does any unlisted code.
  - Letters: a=1C b=32 c=21 d=23 e=24 f=2B g=34 h=33 i=43 j=3B k=42 l=4B m=3A n=31 o=44 p=4D q=15 r=2D s=1B t=2C u=3C v=2A w=1D x=22 y=35 z=1A.
  - Letter case: lowercase (0x61–0x7A) by default, uppercase (0x41–0x5A) when `shift`^`caps`.
  - Digits, unaffected by shift: 0=45 1=16 2=1E 3=26 4=25 5=2E 6=36 7=3D 8=3E 9=46.
  - Space: 29→0x20. Enter: 5A→0x0D. Backspace: 66→0x08.
  - Break events carry the same ASCII as the corresponding make would.
- **`press_cnt`:** increments by 1 on entry to EMIT with `ev_break`=0, including typematic repeats. Wraps modulo 2^CNT_W.
- **`err`:** set on any cycle with `kb_overflow`=1, or on a protocol error. Cleared only by `rst`.

## Timing

- **Reset values:** state=IDLE; every output 0, including `kb_nextdata`, `ev_*`, `shift`, `caps`, `press_cnt` and `err`. Prefix and held bits are also 0.
- **Latency:** `kb_ready` sampled high in cycle N → `kb_nextdata`=1 in N+1 → `ev_valid`=1 from N+2 (for a non-prefix byte).
- **Pops:** exactly one `kb_nextdata` pulse per consumed byte, never two in consecutive cycles. The receiver's `ready` and `data` are re-sampled only in IDLE, one cycle after the pulse.
- **Prefix bytes:** cost 2 cycles each and produce no event.
- **Backpressure:** while EMIT and `ev_ready`=0, the event outputs stay stable and no byte is popped, so the receiver FIFO absorbs incoming bytes.
- **Handshake:** transfer occurs on the cycle where `ev_valid`&`ev_ready`=1. The earliest next `kb_nextdata` is 2 cycles later.
- **Mid-operation reset:** a `rst` in any state discards the pending byte, prefixes and event, with no pop in that cycle. The receiver is reset by the same `rst`.

## Test plan

- Byte `1C`, `ev_ready`=1 → one event: code=1C, ext=0, break=0, ascii=0x61, `press_cnt`=1. One `kb_nextdata` pulse; `ev_valid` asserted 2 cycles after `kb_ready`.
- Bytes `1C F0 1C` → two events. The second has break=1, ascii=0x61, and `press_cnt` stays 1. Exactly 3 `kb_nextdata` pulses.
- Bytes `12 1C F0 12 1C` → ascii of the `1C` events is 0x41 then 0x61. `shift` reads 1 after the first event and 0 after the `F0 12` event.
- Bytes `58 58 F0 58 1C` → `caps` goes to 1 and is not toggled by the repeated `58`; the `1C` event has ascii=0x41. Then `58 F0 58` → `caps`=0.
- Bytes `E0 F0 75` with `ev_ready` held low 5 cycles → a single event with ext=1, break=1, code=75, ascii=0, held stable for those 5 cycles with no pops; it is accepted on the 6th cycle.
- A `kb_overflow` pulse → `err`=1 and it persists; sequence `F0 F0 1C` → `err`=1 and the `1C` event has break=0. Asserting `rst` during EMIT → all outputs 0 next cycle, and no event is emitted afterwards.
